// File: rtl/ifu_if.sv
// Fetch-unit signal bundle: execute-stage redirect, memory request/response, decoder handoff.
interface ifu_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport slave (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
  );

  modport master (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding 64-bit read at a time, selects the 32-bit half by
// pc[2], and queues {pc, inst} pairs for decode. Redirects flush and may leave a read to drop.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic clk,
  input  logic rst,
  ifu_if.slave bus
);
  localparam int          PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t        r_state, w_state_nxt;
  logic [63:0]   r_fetch_pc;
  logic [63:0]   r_buf_pc   [DEPTH];
  logic [31:0]   r_buf_inst [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_redir, w_req_v, w_push, w_pop;
  logic [31:0]   w_rsp_word;

  // Redirect blocks the request and kills any same-cycle push or pop.
  assign w_redir    = bus.redirect_valid;
  assign w_req_v    = rst && (r_state == S_REQ) && (r_count != FULL) && !w_redir;
  assign w_push     = (r_state == S_WAIT) && bus.mem_rsp_valid && !w_redir;
  assign w_pop      = (r_count != '0) && bus.inst_ready && !w_redir;
  assign w_rsp_word = r_fetch_pc[2] ? bus.mem_rsp_data[63:32] : bus.mem_rsp_data[31:0];

  assign bus.mem_req_valid = w_req_v;
  assign bus.mem_req_addr  = {r_fetch_pc[63:3], 3'b000};
  assign bus.inst_valid    = (r_count != '0);
  assign bus.inst          = r_buf_inst[r_rd_ptr];
  assign bus.inst_pc       = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_REQ;
    else      r_state <= w_state_nxt;
  end

  // A response always closes the outstanding read, whether or not it is kept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_v && bus.mem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (bus.mem_rsp_valid)            w_state_nxt = S_REQ;
               else if (w_redir)                 w_state_nxt = S_DROP;
      S_DROP:  if (bus.mem_rsp_valid)            w_state_nxt = S_REQ;
      default:                                   w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         r_fetch_pc <= RESET_PC;
    else if (w_redir) r_fetch_pc <= bus.redirect_pc & ~64'd3;
    else if (w_push)  r_fetch_pc <= r_fetch_pc + 64'd4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_buf_pc[i]   <= '0;
        r_buf_inst[i] <= '0;
      end
    end else if (w_redir) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
        r_buf_inst[r_wr_ptr] <= w_rsp_word;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end
endmodule
